// File: rtl/cpu_clock_pkg.sv
// Shared state encodings and widths for the processor clock-enable controller.
package cpu_clock_pkg;
    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_STEP = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    localparam int STEP_COUNT_W = 16;
    localparam int DEBOUNCE_W   = 20;

    typedef enum logic [1:0] {
        S_RUN  = ST_RUN,
        S_STEP = ST_STEP,
        S_HALT = ST_HALT
    } clk_state_t;
endpackage

// File: rtl/button_debouncer.sv
// Raw pushbutton to one-cycle press pulse: 2-flop sync, counted debounce, rising-edge pulse.
module button_debouncer
    import cpu_clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20
) (
    input  logic clock_in,
    input  logic reset,
    input  logic btn,
    output logic press
);
    localparam logic [DEBOUNCE_W-1:0] LAST = DEBOUNCE_W'(DEBOUNCE_CYCLES - 1);

    logic                  btn_meta;
    logic                  btn_sync;
    logic                  level;
    logic                  level_prev;
    logic [DEBOUNCE_W-1:0] count;

    always_ff @(posedge clock_in) begin
        if (reset) begin
            btn_meta   <= 1'b0;
            btn_sync   <= 1'b0;
            level      <= 1'b0;
            level_prev <= 1'b0;
            count      <= '0;
            press      <= 1'b0;
        end else begin
            btn_meta   <= btn;
            btn_sync   <= btn_meta;
            level_prev <= level;
            press      <= level & ~level_prev;
            // Any cycle where the synced level agrees with the accepted one restarts the count.
            if (btn_sync == level) begin
                count <= '0;
            end else if (count == LAST) begin
                level <= btn_sync;
                count <= '0;
            end else begin
                count <= count + DEBOUNCE_W'(1);
            end
        end
    end
endmodule

// File: rtl/cpu_clock_ctrl.sv
// Converts the divided clock and debug buttons into single-cycle processor enable pulses,
// with free-run, single-step and processor-driven halt/resume.
module cpu_clock_ctrl
    import cpu_clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int HOLDOFF_CYCLES  = 2
) (
    input  logic                    clock_in,
    input  logic                    reset,
    input  logic                    tick_in,
    input  logic                    run_mode,
    input  logic                    step_btn,
    input  logic                    resume_btn,
    input  logic                    halt_req,
    output logic                    cpu_enable,
    output logic                    halted,
    output logic [STEP_COUNT_W-1:0] step_count,
    output logic [1:0]              state_dbg
);
    localparam int HOLD_W = (HOLDOFF_CYCLES < 2) ? 1 : $clog2(HOLDOFF_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF_CYCLES);

    logic tick_meta, tick_sync, tick_prev;
    logic run_meta, run_sync;
    logic tick_rise;
    logic step_press, resume_press;

    clk_state_t        state, state_next;
    logic              enable_next;
    logic [HOLD_W-1:0] holdoff, holdoff_next;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
        .clock_in (clock_in),
        .reset    (reset),
        .btn      (step_btn),
        .press    (step_press)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_resume_db (
        .clock_in (clock_in),
        .reset    (reset),
        .btn      (resume_btn),
        .press    (resume_press)
    );

    // Tick flops reset high so a divider output already high at reset is not seen as an edge.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            tick_meta <= 1'b1;
            tick_sync <= 1'b1;
            tick_prev <= 1'b1;
            run_meta  <= 1'b0;
            run_sync  <= 1'b0;
        end else begin
            tick_meta <= tick_in;
            tick_sync <= tick_meta;
            tick_prev <= tick_sync;
            run_meta  <= run_mode;
            run_sync  <= run_meta;
        end
    end

    assign tick_rise = tick_sync & ~tick_prev;

    always_comb begin
        state_next   = state;
        enable_next  = 1'b0;
        holdoff_next = (holdoff != '0) ? holdoff - HOLD_W'(1) : '0;
        case (state)
            S_RUN: begin
                if (halt_req && holdoff == '0) begin
                    state_next = S_HALT;
                end else begin
                    enable_next = tick_rise;
                    if (!run_sync) state_next = S_STEP;
                end
            end
            S_STEP: begin
                if (halt_req && holdoff == '0) begin
                    state_next = S_HALT;
                end else begin
                    enable_next = step_press;
                    if (run_sync) state_next = S_RUN;
                end
            end
            S_HALT: begin
                if (resume_press) begin
                    enable_next  = 1'b1;
                    holdoff_next = HOLD_LOAD;
                    state_next   = run_sync ? S_RUN : S_STEP;
                end
            end
            default: state_next = S_STEP;
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            state      <= S_STEP;
            holdoff    <= '0;
            cpu_enable <= 1'b0;
            halted     <= 1'b0;
            step_count <= '0;
        end else begin
            state      <= state_next;
            holdoff    <= holdoff_next;
            cpu_enable <= enable_next;
            halted     <= (state_next == S_HALT);
            if (enable_next) step_count <= step_count + STEP_COUNT_W'(1);
        end
    end

    assign state_dbg = state;
endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Scoreboarded bench for cpu_clock_ctrl: expected enable cycles are queued by the drivers
// and matched by a negedge monitor; level outputs are checked directly.
module tb_cpu_clock_ctrl;
    import cpu_clock_pkg::*;

    localparam int DEB     = 20;
    localparam int HOLDOFF = 2;
    // Press held from the first sampling edge appears on cpu_enable DEB+3 edges later.
    localparam int BTN_LAT  = DEB + 4;
    localparam int TICK_LAT = 3;

    logic        clock_in = 1'b0;
    logic        reset;
    logic        tick_in;
    logic        run_mode;
    logic        step_btn;
    logic        resume_btn;
    logic        halt_req;
    logic        cpu_enable;
    logic        halted;
    logic [15:0] step_count;
    logic [1:0]  state_dbg;

    int          cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];

    cpu_clock_ctrl #(.DEBOUNCE_CYCLES(DEB), .HOLDOFF_CYCLES(HOLDOFF)) dut (
        .clock_in   (clock_in),
        .reset      (reset),
        .tick_in    (tick_in),
        .run_mode   (run_mode),
        .step_btn   (step_btn),
        .resume_btn (resume_btn),
        .halt_req   (halt_req),
        .cpu_enable (cpu_enable),
        .halted     (halted),
        .step_count (step_count),
        .state_dbg  (state_dbg)
    );

    // Clock and cycle counter.
    always #5 clock_in = ~clock_in;
    always @(posedge clock_in) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at time %0t, limit 100000", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every enable pulse must match the next queued cycle.
    always @(negedge clock_in) begin
        if (cpu_enable === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_pulse: cpu_enable=1 at cycle %0d, no pulse due", cyc);
            end else begin
                check("pulse_cycle", 32'(cyc), exp_q.pop_front());
            end
        end
    end

    // Drivers; all called at a negedge.
    task automatic wait_neg(input int n);
        repeat (n) @(negedge clock_in);
    endtask

    task automatic tick_period(input bit expect_pulse);
        tick_in = 1'b1;
        if (expect_pulse) exp_q.push_back(32'(cyc + TICK_LAT));
        wait_neg(10);
        tick_in = 1'b0;
        wait_neg(10);
    endtask

    task automatic check_outputs(input string tag, input logic en, input logic hl,
                                 input logic [15:0] cnt, input logic [1:0] st);
        check({tag, "_cpu_enable"}, 32'(cpu_enable), 32'(en));
        check({tag, "_halted"}, 32'(halted), 32'(hl));
        check({tag, "_step_count"}, 32'(step_count), 32'(cnt));
        check({tag, "_state"}, 32'(state_dbg), 32'(st));
    endtask

    initial begin
        int m;
        reset = 1'b1; tick_in = 1'b0; run_mode = 1'b0;
        step_btn = 1'b0; resume_btn = 1'b0; halt_req = 1'b0;
        wait_neg(3);
        check_outputs("reset", 1'b0, 1'b0, 16'd0, ST_STEP);

        // Free run: five ticks, five pulses three cycles after each rise.
        reset = 1'b0;
        run_mode = 1'b1;
        wait_neg(6);
        for (int i = 0; i < 5; i++) tick_period(1'b1);
        check("run_step_count", 32'(step_count), 32'd5);
        check("run_state", 32'(state_dbg), 32'(ST_RUN));
        check("run_pending", 32'(exp_q.size()), 32'd0);

        // Single step with a bouncing button: only the final stable hold counts.
        run_mode = 1'b0;
        wait_neg(6);
        for (int i = 0; i < 3; i++) begin
            step_btn = 1'b1; wait_neg(5);
            step_btn = 1'b0; wait_neg(5);
        end
        step_btn = 1'b1;
        exp_q.push_back(32'(cyc + BTN_LAT));
        wait_neg(30);
        step_btn = 1'b0;
        wait_neg(30);
        check("step_step_count", 32'(step_count), 32'd6);
        check("step_state", 32'(state_dbg), 32'(ST_STEP));
        check("step_pending", 32'(exp_q.size()), 32'd0);

        // Halt request coincident with a tick rise swallows that pulse.
        run_mode = 1'b1;
        wait_neg(6);
        tick_in = 1'b1;
        wait_neg(2);
        halt_req = 1'b1;
        wait_neg(1);
        check("halt_entry_halted", 32'(halted), 32'd1);
        check("halt_entry_state", 32'(state_dbg), 32'(ST_HALT));
        wait_neg(8);
        tick_in = 1'b0;
        wait_neg(10);
        tick_period(1'b0);
        tick_period(1'b0);
        check("halt_hold_count", 32'(step_count), 32'd6);
        check("halt_hold_halted", 32'(halted), 32'd1);

        // Resume: one pulse, then halt_req ignored for the holdoff window.
        resume_btn = 1'b1;
        m = cyc;
        exp_q.push_back(32'(m + BTN_LAT));
        wait_neg(BTN_LAT);
        check("resume_halted", 32'(halted), 32'd0);
        check("resume_state", 32'(state_dbg), 32'(ST_RUN));
        wait_neg(1);
        check("holdoff1_halted", 32'(halted), 32'd0);
        wait_neg(1);
        check("holdoff2_halted", 32'(halted), 32'd0);
        wait_neg(1);
        check("rehalt_halted", 32'(halted), 32'd1);
        halt_req = 1'b0;
        resume_btn = 1'b0;
        wait_neg(30);
        resume_btn = 1'b1;
        exp_q.push_back(32'(cyc + BTN_LAT));
        wait_neg(30);
        resume_btn = 1'b0;
        wait_neg(30);
        check("resume2_count", 32'(step_count), 32'd8);
        check("resume2_halted", 32'(halted), 32'd0);
        check("resume_pending", 32'(exp_q.size()), 32'd0);

        // Counter wrap: preload the counter to its top value, then one more pulse.
        force dut.step_count = 16'hFFFF;
        #1;
        release dut.step_count;
        wait_neg(1);
        check("preload_count", 32'(step_count), 32'h0000_FFFF);
        tick_period(1'b1);
        check("wrap_count", 32'(step_count), 32'd0);
        check("wrap_pending", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a debounce with tick_in held high.
        tick_in = 1'b1;
        exp_q.push_back(32'(cyc + TICK_LAT));
        step_btn = 1'b1;
        wait_neg(10);
        reset = 1'b1;
        wait_neg(1);
        check_outputs("midreset", 1'b0, 1'b0, 16'd0, ST_STEP);
        wait_neg(2);
        reset = 1'b0;
        step_btn = 1'b0;
        wait_neg(30);
        check("postreset_state", 32'(state_dbg), 32'(ST_RUN));
        check("postreset_count", 32'(step_count), 32'd0);
        run_mode = 1'b0;
        wait_neg(6);
        step_btn = 1'b1;
        exp_q.push_back(32'(cyc + BTN_LAT));
        wait_neg(30);
        step_btn = 1'b0;
        wait_neg(5);
        check("postreset_step_count", 32'(step_count), 32'd1);
        check("final_pending", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
